// File: rtl/imem_pkg.sv
// imem_pkg: shared defaults, latency limits and index-width helper.
// Imported by instr_mem_pipe and imem_rsp_fifo.
package imem_pkg;

    localparam int IMEM_DATA_W_DEF = 32;
    localparam int IMEM_DEPTH_DEF  = 128;
    localparam int IMEM_ADDR_W_DEF = 32;
    localparam int IMEM_BYTE_DEF   = 1;
    localparam int IMEM_LAT_DEF    = 1;
    localparam int IMEM_LAT_MIN    = 1;
    localparam int IMEM_LAT_MAX    = 3;

    // Bits needed to index n entries (never less than 1).
    function automatic int imem_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo: small response FIFO with synchronous flush.
// Ports: i_push/i_data write, i_pop/o_valid/o_data read (o_data=0 when empty).
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int WIDTH = IMEM_DATA_W_DEF + 1,
    parameter int DEPTH = IMEM_LAT_DEF + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam int PW = imem_idx_w(DEPTH);
    localparam int CW = imem_idx_w(DEPTH + 1);

    logic [WIDTH-1:0] r_buf [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic             w_pop;

    function automatic logic [PW-1:0] f_inc(
        input logic [PW-1:0] p
    );
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_pop = i_pop & (r_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push)
                r_wp <= f_inc(r_wp);
            if (w_pop)
                r_rp <= f_inc(r_rp);
            if (i_push && !w_pop)
                r_cnt <= r_cnt + CW'(1);
            else if (!i_push && w_pop)
                r_cnt <= r_cnt - CW'(1);
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (i_push)
            r_buf[r_wp] <= i_data;
    end

    assign o_valid = (r_cnt != '0);
    assign o_data  = o_valid ? r_buf[r_rp] : '0;

endmodule

// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe: pipelined instruction memory, valid/ready fetch, flush,
// in-order response FIFO. Define IMEM_PROG_PORT_EN to add prog_* write port.
// Ports: clk, rst_n, req_valid/ready/addr, flush, rsp_valid/ready/data/err.
module instr_mem_pipe
    import imem_pkg::*;
#(
    parameter int DATA_W    = IMEM_DATA_W_DEF,
    parameter int DEPTH     = IMEM_DEPTH_DEF,
    parameter int ADDR_W    = IMEM_ADDR_W_DEF,
    parameter int BYTE_ADDR = IMEM_BYTE_DEF,
    parameter int LAT       = IMEM_LAT_DEF,
    parameter     INIT_FILE = ""
) (
    input  logic                        clk,
    input  logic                        rst_n,
`ifdef IMEM_PROG_PORT_EN
    input  logic                        prog_we,
    input  logic [imem_idx_w(DEPTH)-1:0] prog_addr,
    input  logic [DATA_W-1:0]           prog_data,
`endif
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic                        flush,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err
);

    localparam int LAT_C =
        (LAT < IMEM_LAT_MIN) ? IMEM_LAT_MIN :
        (LAT > IMEM_LAT_MAX) ? IMEM_LAT_MAX : LAT;
    localparam int IW    = imem_idx_w(DEPTH);
    localparam int LSB   = (BYTE_ADDR != 0) ? 2 : 0;
    localparam int TOP   = IW + LSB;
    localparam int OCC_W = imem_idx_w(LAT_C + 2);
    localparam logic [OCC_W-1:0] OCC_MAX =
        OCC_W'(LAT_C + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [IW-1:0]     w_idx;
    logic              w_hi;
    logic              w_mis;
    logic              w_err;
    logic [DATA_W-1:0] w_rd;
    logic              w_acc;
    logic              w_cons;
    logic              w_push;
    logic [DATA_W:0]   w_pdat;
    logic              w_fvalid;
    logic [DATA_W:0]   w_fdata;
    logic [OCC_W-1:0]  w_occ_nxt;
    logic [OCC_W-1:0]  r_occ;
    logic              r_ready;

    // Contents start at zero; reset never touches them.
    initial begin
        for (int i = 0; i < DEPTH; i++)
            r_mem[i] = '0;
    end

`ifdef IMEM_PROG_PORT_EN
    // Fetch reads r_mem combinationally before this edge: old data wins.
    always_ff @(posedge clk) begin
        if (prog_we)
            r_mem[prog_addr] <= prog_data;
    end
`endif

    assign w_idx = req_addr[TOP-1:LSB];

    generate
        if (ADDR_W > TOP) begin : g_hi
            assign w_hi = |req_addr[ADDR_W-1:TOP];
        end else begin : g_nohi
            assign w_hi = 1'b0;
        end
        if (BYTE_ADDR != 0) begin : g_byte
            assign w_mis = |req_addr[1:0];
        end else begin : g_word
            assign w_mis = 1'b0;
        end
    endgenerate

    assign w_err = w_hi | w_mis;
    assign w_rd  = w_err ? '0 : r_mem[w_idx];

    assign req_ready = r_ready & ~flush;
    assign w_acc     = req_valid & req_ready;
    assign w_cons    = w_fvalid & rsp_ready;

    // The FIFO write is the last of the LAT register stages,
    // so LAT-1 explicit stages sit in front of it.
    generate
        if (LAT_C == 1) begin : g_lat1
            assign w_push = w_acc;
            assign w_pdat = {w_err, w_rd};
        end else begin : g_latn
            logic [LAT_C-2:0] r_pv;
            logic [DATA_W:0]  r_pd [LAT_C-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pv <= '0;
                    for (int i = 0; i < LAT_C - 1; i++)
                        r_pd[i] <= '0;
                end else begin
                    r_pv[0] <= w_acc & ~flush;
                    r_pd[0] <= {w_err, w_rd};
                    for (int i = 1; i < LAT_C - 1; i++) begin
                        r_pv[i] <= r_pv[i-1] & ~flush;
                        r_pd[i] <= r_pd[i-1];
                    end
                end
            end

            assign w_push = r_pv[LAT_C-2];
            assign w_pdat = r_pd[LAT_C-2];
        end
    endgenerate

    imem_rsp_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (LAT_C + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  (w_pdat),
        .i_pop   (w_cons),
        .o_valid (w_fvalid),
        .o_data  (w_fdata)
    );

    assign rsp_valid = w_fvalid;
    assign rsp_err   = w_fdata[DATA_W];
    assign rsp_data  = w_fdata[DATA_W-1:0];

    // Occupancy covers in-flight plus buffered, so the FIFO
    // can never overflow and backpressure never drops data.
    always_comb begin
        w_occ_nxt = r_occ;
        if (flush)
            w_occ_nxt = '0;
        else if (w_acc && !w_cons)
            w_occ_nxt = r_occ + OCC_W'(1);
        else if (!w_acc && w_cons)
            w_occ_nxt = r_occ - OCC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_ready <= ~flush & (w_occ_nxt < OCC_MAX);
        end
    end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// tb_instr_mem_pipe: randomized and directed checks of instr_mem_pipe
// against a queue-based response model.
module tb_instr_mem_pipe;

    localparam int DW    = 32;
    localparam int DEPTH = 128;
    localparam int AW    = 32;
    localparam int LAT   = 2;
    localparam int IW    = 7;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          req_valid = 1'b0;
    logic          flush     = 1'b0;
    logic          rsp_ready = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_data;
`ifdef IMEM_PROG_PORT_EN
    logic          prog_we   = 1'b0;
    logic [IW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_data = '0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_mem_pipe #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .ADDR_W    (AW),
        .BYTE_ADDR (1),
        .LAT       (LAT),
        .INIT_FILE ("")
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef IMEM_PROG_PORT_EN
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    // Model: queue of accepted responses, each visible from
    // accept cycle + LAT until consumed.
    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        int            t;
    } rsp_t;

    rsp_t          q[$];
    logic [DW-1:0] mm [DEPTH];
    int            cyc     = 0;
    bit            primed  = 1'b0;
    bit            fl_prev = 1'b0;

    function automatic rsp_t ref_rsp(
        input logic [AW-1:0] a,
        input int            t
    );
        rsp_t r;
        r.e = ((a % 4) != 0) || ((a / 4) >= DEPTH);
        r.d = '0;
        if (!r.e)
            r.d = mm[a / 4];
        r.t = t;
        return r;
    endfunction

    function automatic bit m_ready();
        return primed && !fl_prev && !flush
            && (q.size() < LAT + 1);
    endfunction

    function automatic bit m_valid();
        return (q.size() > 0) && (q[0].t <= cyc);
    endfunction

    task automatic tick();
        bit   acc;
        bit   con;
        rsp_t r;
        acc = req_valid && m_ready();
        con = m_valid() && rsp_ready;
        r   = ref_rsp(req_addr, cyc + LAT);
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            primed  = 1'b0;
            fl_prev = 1'b0;
        end else begin
            if (con)
                void'(q.pop_front());
            if (acc)
                q.push_back(r);
            if (flush)
                q.delete();
            fl_prev = flush;
            primed  = 1'b1;
        end
        cyc++;
        #1;
    endtask

    task automatic load_mem();
        for (int i = 0; i < DEPTH; i++)
            mm[i] = DW'(i);
`ifdef IMEM_PROG_PORT_EN
        for (int i = 0; i < DEPTH; i++) begin
            prog_we   = 1'b1;
            prog_addr = IW'(i);
            prog_data = mm[i];
            tick();
        end
        prog_we = 1'b0;
`else
        #1;
        for (int i = 0; i < DEPTH; i++)
            u_dut.r_mem[i] = mm[i];
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        q.delete();
        primed = 1'b0;
        @(negedge clk);
        checks += 4;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready got=%b exp=0", req_ready);
        end
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got=%b exp=0", rsp_valid);
        end
        if (rsp_data !== '0) begin
            errors++;
            $display("FAIL rst_data got=%h exp=0", rsp_data);
        end
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_err got=%b exp=0", rsp_err);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rel_ready0 got=%b exp=0", req_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rel_ready1 got=%b exp=1", req_ready);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit ev;
        rsp_ready = 1'b1;
        for (int c = 0; c < LAT + 4; c++) begin
            req_valid = (c < 3);
            req_addr  = AW'(c * 4);
            @(negedge clk);
            if (c < 3) begin
                checks++;
                if (req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready c=%0d got=%b exp=1",
                             c, req_ready);
                end
            end
            ev = (c >= LAT) && (c < LAT + 3);
            checks++;
            if (rsp_valid !== ev) begin
                errors++;
                $display("FAIL b2b_valid c=%0d got=%b exp=%b",
                         c, rsp_valid, ev);
            end
            if (ev) begin
                checks++;
                if (rsp_data !== mm[c - LAT]) begin
                    errors++;
                    $display("FAIL b2b_data c=%0d got=%h exp=%h",
                             c, rsp_data, mm[c - LAT]);
                end
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int n_acc;
        int got;
        bit take;
        n_acc     = 0;
        got       = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== m_ready()) begin
                errors++;
                $display("FAIL bp_ready c=%0d got=%b exp=%b",
                         c, req_ready, m_ready());
            end
            take = (req_ready === 1'b1);
            tick();
            if (take) begin
                n_acc++;
                req_addr = req_addr + 32'd4;
            end
        end
        checks++;
        if (n_acc != LAT + 1) begin
            errors++;
            $display("FAIL bp_accepts got=%0d exp=%0d",
                     n_acc, LAT + 1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && got < LAT + 1; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                checks++;
                if (rsp_data !== mm[4 + got]) begin
                    errors++;
                    $display("FAIL bp_data n=%0d got=%h exp=%h",
                             got, rsp_data, mm[4 + got]);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != LAT + 1) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=%0d",
                     got, LAT + 1);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_extra got=%b exp=0", rsp_valid);
        end
        tick();
    endtask

    task automatic test_errors();
        logic [AW-1:0] ea [5];
        logic          ee [5];
        logic [DW-1:0] ed;
        int            sent;
        int            got;
        bit            take;
        ea = '{32'h202, 32'h200, 32'h8000_0000,
               32'h1FC, 32'h201};
        ee = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        sent      = 0;
        got       = 0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 30 && got < 5; c++) begin
            req_valid = (sent < 5);
            req_addr  = ea[(sent < 5) ? sent : 4];
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                ed = '0;
                if (!ee[got])
                    ed = mm[ea[got] / 4];
                checks += 2;
                if (rsp_err !== ee[got]) begin
                    errors++;
                    $display("FAIL err_flag a=%h got=%b exp=%b",
                             ea[got], rsp_err, ee[got]);
                end
                if (rsp_data !== ed) begin
                    errors++;
                    $display("FAIL err_data a=%h got=%h exp=%h",
                             ea[got], rsp_data, ed);
                end
                got++;
            end
            take = req_valid && (req_ready === 1'b1);
            tick();
            if (take)
                sent++;
        end
        req_valid = 1'b0;
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL err_count got=%0d exp=5", got);
        end
    endtask

    task automatic test_flush();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h20;
        @(negedge clk);
        tick();
        req_addr = 32'h24;
        @(negedge clk);
        tick();
        req_addr = 32'h28;
        flush    = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL fl_ready_now got=%b exp=0", req_ready);
        end
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fl_valid got=%b exp=0", rsp_valid);
        end
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL fl_ready1 got=%b exp=0", req_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL fl_ready2 got=%b exp=1", req_ready);
        end
        tick();
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL fl_stale c=%0d got=%b exp=0",
                         c, rsp_valid);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h30;
        @(negedge clk);
        tick();
        req_addr = 32'h34;
        @(negedge clk);
        tick();
        req_valid = 1'b0;
        rst_n     = 1'b0;
        q.delete();
        primed = 1'b0;
        #1;
        checks += 4;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_ready got=%b exp=0", req_ready);
        end
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_valid got=%b exp=0", rsp_valid);
        end
        if (rsp_data !== '0) begin
            errors++;
            $display("FAIL mid_data got=%h exp=0", rsp_data);
        end
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_err got=%b exp=0", rsp_err);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rel0 got=%b exp=0", req_ready);
        end
        tick();
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks += 2;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_rel1 c=%0d got=%b exp=1",
                         c, req_ready);
            end
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_lost c=%0d got=%b exp=0",
                         c, rsp_valid);
            end
            tick();
        end
    endtask

`ifdef IMEM_PROG_PORT_EN
    task automatic test_prog();
        logic [DW-1:0] ex [2];
        int            got;
        got       = 0;
        ex[0]     = mm[5];
        ex[1]     = 32'hDEAD_BEEF;
        rsp_ready = 1'b1;
        prog_we   = 1'b1;
        prog_addr = IW'(5);
        prog_data = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr  = 32'h14;
        @(negedge clk);
        tick();
        mm[5]   = 32'hDEAD_BEEF;
        prog_we = 1'b0;
        @(negedge clk);
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                checks++;
                if (rsp_data !== ex[got]) begin
                    errors++;
                    $display("FAIL prog_data n=%0d got=%h exp=%h",
                             got, rsp_data, ex[got]);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL prog_count got=%0d exp=2", got);
        end
    endtask
`endif

    task automatic test_random();
        logic [DW-1:0] ed;
        logic          ee;
        bit            ev;
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 5))
                0: req_addr = AW'($urandom);
                1: req_addr = {23'd0, 7'($urandom),
                               2'($urandom_range(1, 3))};
                2: req_addr = AW'($urandom_range(DEPTH,
                               4 * DEPTH - 1)) << 2;
                default: req_addr = {23'd0, 7'($urandom),
                                     2'b00};
            endcase
            @(negedge clk);
            ev = m_valid();
            ed = ev ? q[0].d : '0;
            ee = ev ? q[0].e : 1'b0;
            checks += 4;
            if (req_ready !== m_ready()) begin
                errors++;
                $display("FAIL rnd_ready c=%0d got=%b exp=%b",
                         c, req_ready, m_ready());
            end
            if (rsp_valid !== ev) begin
                errors++;
                $display("FAIL rnd_valid c=%0d got=%b exp=%b",
                         c, rsp_valid, ev);
            end
            if (rsp_data !== ed) begin
                errors++;
                $display("FAIL rnd_data c=%0d got=%h exp=%h",
                         c, rsp_data, ed);
            end
            if (rsp_err !== ee) begin
                errors++;
                $display("FAIL rnd_err c=%0d got=%b exp=%b",
                         c, rsp_err, ee);
            end
            tick();
        end
        req_valid = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
    endtask

    initial begin
        load_mem();
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_flush();
        test_reset_mid();
`ifdef IMEM_PROG_PORT_EN
        test_prog();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
